// File: rtl/coreport_arb.sv
// Round-robin Wishbone arbiter in front of the coreport GPIO slave.
// One master owns the slave for its whole bus cycle (cyc high). A per-transfer
// watchdog turns a stalled strobe into a one-cycle error to the owner.
module coreport_arb #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 8,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 15
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst_n,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_MASTERS-1:0]    gnt_o,
  output logic                      busy_o
);

  localparam int LW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_I);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [LW-1:0]          last_q, last_d;   // also the current owner while in OWN
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [LW-1:0]          win;
  logic                   found;
  logic                   stall;

  // Round-robin search: first requester strictly after last, then wrap around.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && (LW'(k) > last_q) && m_cyc_i[k]) begin
        found = 1'b1;
        win   = LW'(k);
      end
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && (LW'(k) <= last_q) && m_cyc_i[k]) begin
        found = 1'b1;
        win   = LW'(k);
      end
    end
  end

  // Route the owner's bus to the slave and the slave's responses to the owner only.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == OWN) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (LW'(k) == last_q) begin
          s_cyc_o    = m_cyc_i[k];
          s_stb_o    = m_stb_i[k] & ~err_q;
          s_we_o     = m_we_i[k];
          s_adr_o    = m_adr_i[k*AW +: AW];
          s_dat_o    = m_dat_i[k*DW +: DW];
          m_ack_o[k] = s_ack_i;
          m_err_o[k] = s_err_i | err_q;
        end
      end
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == OWN);
  assign stall   = s_stb_o & ~s_ack_i & ~s_err_i;

  // Grant FSM: IDLE picks a winner, OWN holds it until the owner drops cyc.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d    = OWN;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          last_d     = win;
        end
      end
      OWN: begin
        if (!s_cyc_o) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Watchdog: count stalled strobe cycles; the pulse fires on the edge where the
  // count would reach TIMEOUT, so an ack at TIMEOUT-1 still wins.
  always_comb begin
    cnt_d = '0;
    err_d = 1'b0;
    if ((TIMEOUT > 0) && (state_q == OWN) && stall) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        err_d = s_cyc_o;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_coreport_arb.sv
// Self-checking bench for coreport_arb: a vector table for single/contended
// transfers plus hand sequences for round-robin order, watchdog and reset.
module tb_coreport_arb;

  logic        wb_clk;
  logic        wb_rst_n;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [63:0] m_adr_i;
  logic [15:0] m_dat_i;
  logic        ack_en;

  logic [7:0]  a_mdat, b_mdat, a_sdat_i, b_sdat_i, a_sdat, b_sdat;
  logic [1:0]  a_ack, b_ack, a_err, b_err, a_gnt, b_gnt;
  logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [31:0] a_adr, b_adr;
  logic        a_sack, b_sack, a_busy, b_busy;

  int errors = 0;
  int checks = 0;

  // Master 0 targets address 0x00 with data A5, master 1 address 0x04 with 5A.
  assign m_adr_i = {32'h0000_0004, 32'h0000_0000};
  assign m_dat_i = {8'h5A, 8'hA5};

  // Slave models: combinational ack, read data is address XOR C3.
  assign a_sack   = a_cyc & a_stb & ack_en;
  assign b_sack   = b_cyc & b_stb & ack_en;
  assign a_sdat_i = a_adr[7:0] ^ 8'hC3;
  assign b_sdat_i = b_adr[7:0] ^ 8'hC3;

  coreport_arb #(.NUM_MASTERS(2), .DW(8), .AW(32), .TIMEOUT(15)) dut_a (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(a_mdat),
    .m_ack_o(a_ack), .m_err_o(a_err),
    .s_cyc_o(a_cyc), .s_stb_o(a_stb), .s_we_o(a_we),
    .s_adr_o(a_adr), .s_dat_o(a_sdat), .s_dat_i(a_sdat_i),
    .s_ack_i(a_sack), .s_err_i(1'b0),
    .gnt_o(a_gnt), .busy_o(a_busy)
  );

  coreport_arb #(.NUM_MASTERS(2), .DW(8), .AW(32), .TIMEOUT(0)) dut_b (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(b_mdat),
    .m_ack_o(b_ack), .m_err_o(b_err),
    .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_we_o(b_we),
    .s_adr_o(b_adr), .s_dat_o(b_sdat), .s_dat_i(b_sdat_i),
    .s_ack_i(b_sack), .s_err_i(1'b0),
    .gnt_o(b_gnt), .busy_o(b_busy)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] cyc, stb, we;
    logic [1:0] gnt, ack;
    logic [2:0] ctl;     // {s_cyc, s_stb, s_we}
    logic [7:0] adr, sdat, mdat;
    logic       busy;
  } vec_t;

  vec_t tbl[12];
  vec_t sbq[$];

  function automatic vec_t mk(logic r, logic [1:0] c, logic [1:0] s, logic [1:0] w,
                              logic [1:0] g, logic [1:0] a, logic [2:0] ctl,
                              logic [7:0] adr, logic [7:0] sd, logic [7:0] md, logic b);
    vec_t v;
    v.rst_n = r; v.cyc = c; v.stb = s; v.we = w; v.gnt = g; v.ack = a;
    v.ctl = ctl; v.adr = adr; v.sdat = sd; v.mdat = md; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(posedge wb_clk); #1;
    wb_rst_n = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; ack_en = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1 wb_rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, leak, got, expv, bbad, quiet;
    logic acked;
    int exp_order[$];
    vec_t e;

    wb_rst_n = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; ack_en = 1'b1;

    // ---- reset state ----
    reset_dut();
    @(negedge wb_clk);
    check("rst_gnt_a",  a_gnt, 0);
    check("rst_busy_a", a_busy, 0);
    check("rst_ack_a",  a_ack, 0);
    check("rst_err_a",  a_err, 0);
    check("rst_ctl_a",  {a_cyc, a_stb, a_we}, 0);
    check("rst_adr_a",  a_adr, 0);
    check("rst_sdat_a", a_sdat, 0);
    check("rst_mdat_a", a_mdat, 8'hC3);
    check("rst_gnt_b",  b_gnt, 0);
    check("rst_ctl_b",  {b_cyc, b_stb, b_we, b_busy}, 0);

    // ---- vector table: single write, then contention after a reset ----
    //          rst  cyc    stb    we     gnt    ack    ctl     adr    sdat   mdat   busy
    tbl[0]  = mk(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000, 8'h00, 8'h00, 8'hC3, 0);
    tbl[1]  = mk(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 3'b111, 8'h00, 8'hA5, 8'hC3, 1);
    tbl[2]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 8'h00, 8'hA5, 8'hC3, 1);
    tbl[3]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 8'h00, 8'h00, 8'hC3, 0);
    tbl[4]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 8'h00, 8'h00, 8'hC3, 0);
    tbl[5]  = mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 8'h00, 8'h00, 8'hC3, 0);
    tbl[6]  = mk(1, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 3'b110, 8'h00, 8'hA5, 8'hC3, 1);
    tbl[7]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 3'b000, 8'h00, 8'hA5, 8'hC3, 1);
    tbl[8]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 8'h00, 8'h00, 8'hC3, 0);
    tbl[9]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 3'b110, 8'h04, 8'h5A, 8'hC7, 1);
    tbl[10] = mk(1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000, 8'h04, 8'h5A, 8'hC7, 1);
    tbl[11] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 8'h00, 8'h00, 8'hC3, 0);

    for (int r = 0; r < 12; r++) begin
      @(posedge wb_clk); #1;
      wb_rst_n = tbl[r].rst_n;
      m_cyc_i  = tbl[r].cyc;
      m_stb_i  = tbl[r].stb;
      m_we_i   = tbl[r].we;
      sbq.push_back(tbl[r]);
      @(negedge wb_clk);
      e = sbq.pop_front();
      check($sformatf("vec%0d_gnt", r),  a_gnt, e.gnt);
      check($sformatf("vec%0d_ack", r),  a_ack, e.ack);
      check($sformatf("vec%0d_ctl", r),  {a_cyc, a_stb, a_we}, e.ctl);
      check($sformatf("vec%0d_adr", r),  a_adr, {24'h0, e.adr});
      check($sformatf("vec%0d_sdat", r), a_sdat, e.sdat);
      check($sformatf("vec%0d_mdat", r), a_mdat, e.mdat);
      check($sformatf("vec%0d_busy", r), a_busy, e.busy);
    end
    @(posedge wb_clk); #1 wb_rst_n = 1'b1;

    // ---- round robin: both request continuously for 6 transfers ----
    reset_dut();
    for (int i = 0; i < 6; i++) exp_order.push_back(i % 2);
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b00;
    n = 0; leak = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge wb_clk);
      if ((a_ack & ~a_gnt) != 2'b00 || a_ack == 2'b11) leak++;
      acked = (a_ack != 2'b00);
      got   = a_ack[1] ? 1 : 0;
      if (acked) begin
        expv = exp_order.pop_front();
        check($sformatf("rr_order%0d", n), got, expv);
        n++;
      end
      @(posedge wb_clk); #1;
      if (acked) begin
        m_cyc_i[got] = 1'b0;
        m_stb_i[got] = 1'b0;
      end else begin
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
      end
    end
    check("rr_count", n, 6);
    check("rr_no_leak", leak, 0);

    // ---- watchdog: stalled slave, TIMEOUT=15 vs TIMEOUT=0 ----
    reset_dut();
    ack_en = 1'b0; m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    bbad = 0;
    @(posedge wb_clk);
    for (int k = 0; k <= 32; k++) begin
      @(negedge wb_clk);
      check($sformatf("wd_err_k%0d", k), a_err, (k == 15 || k == 31) ? 2'b01 : 2'b00);
      check($sformatf("wd_stb_k%0d", k), a_stb, (k == 15 || k == 31) ? 1'b0 : 1'b1);
      if (b_err != 2'b00 || b_stb != 1'b1) bbad++;
      @(posedge wb_clk);
    end
    check("wd_disabled_no_err", bbad, 0);

    // ---- ack at counter 14 wins; later pulse pending while cyc drops ----
    reset_dut();
    ack_en = 1'b0; m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    quiet = 0;
    @(posedge wb_clk);
    for (int k = 0; k <= 47; k++) begin
      @(negedge wb_clk);
      if (k == 14 || k == 29 || k == 30 || k >= 45) begin
        check($sformatf("late_ack_k%0d", k), a_ack, (k == 14) ? 2'b01 : 2'b00);
        check($sformatf("late_err_k%0d", k), a_err, (k == 30 || k == 46) ? 2'b01 : 2'b00);
        check($sformatf("late_gnt_k%0d", k), a_gnt, (k <= 46) ? 2'b01 : 2'b00);
      end else if (a_err != 2'b00) begin
        quiet++;
      end
      @(posedge wb_clk); #1;
      ack_en = (k + 1 == 14);
      if (k + 1 >= 46) begin
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
      end
    end
    check("late_no_stray_err", quiet, 0);

    // ---- reset during master 1's burst ----
    reset_dut();
    ack_en = 1'b1; m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    @(negedge wb_clk);
    check("mrst_idle_gnt", a_gnt, 2'b00);
    @(posedge wb_clk); #1;
    @(negedge wb_clk);
    check("mrst_own_gnt", a_gnt, 2'b10);
    check("mrst_own_ack", a_ack, 2'b10);
    @(posedge wb_clk); #1 wb_rst_n = 1'b0;
    @(negedge wb_clk);
    check("mrst_pre_gnt", a_gnt, 2'b10);
    @(posedge wb_clk); #1;
    wb_rst_n = 1'b1; m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b00;
    @(negedge wb_clk);
    check("mrst_post_gnt",  a_gnt, 2'b00);
    check("mrst_post_busy", a_busy, 1'b0);
    check("mrst_post_ack",  a_ack, 2'b00);
    @(posedge wb_clk); #1;
    @(negedge wb_clk);
    check("mrst_regrant_gnt", a_gnt, 2'b01);
    check("mrst_regrant_ack", a_ack, 2'b01);
    @(posedge wb_clk); #1;
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    repeat (2) @(posedge wb_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coreport_arb.md
# coreport_arb

Round-robin Wishbone arbiter that shares one GPIO port slave (the 8-bit `coreport` register file) between several bus masters, e.g. a CPU and a DMA or bit-bang sequencer. Each master owns the slave for its whole bus cycle, from `cyc` rising until `cyc` falling. A per-transfer watchdog converts a missing slave acknowledge into a one-cycle error to the owning master. It sits between the masters' Wishbone ports and the `coreport` slave port.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters, 2..8.
- `DW`, 8: data width; equals the GPIO port `WIDTH`.
- `AW`, 32: address width.
- `TIMEOUT`, 15: stalled-strobe cycles before an error; 0 disables the watchdog.

Ports:
- `wb_clk`  in  1  single clock; all logic is on the rising edge.
- `wb_rst_n`  in  1  reset; synchronous and active-low.
- `m_cyc_i`  in  NUM_MASTERS  per-master cycle request.
- `m_stb_i`  in  NUM_MASTERS  per-master strobe.
- `m_we_i`  in  NUM_MASTERS  per-master write enable.
- `m_adr_i`  in  NUM_MASTERS*AW  packed addresses; master k occupies `[k*AW +: AW]`.
- `m_dat_i`  in  NUM_MASTERS*DW  packed write data; master k occupies `[k*DW +: DW]`.
- `m_dat_o`  out  DW  read data, shared by all masters; equal to `s_dat_i`.
- `m_ack_o`  out  NUM_MASTERS  per-master acknowledge.
- `m_err_o`  out  NUM_MASTERS  per-master error.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave controls.
- `s_adr_o`  out  AW  slave address.
- `s_dat_o`  out  DW  slave write data.
- `s_dat_i`  in  DW  slave read data.
- `s_ack_i`, `s_err_i`  in  1  slave responses.
- `gnt_o`  out  NUM_MASTERS  registered one-hot grant.
- `busy_o`  out  1  high in OWN state.

## Operation
- The FSM has two states, IDLE and OWN.
- Round-robin pointer `last`:
  - Index of the most recently granted master.
  - Reset value NUM_MASTERS-1, so master 0 wins first.
- IDLE:
  - `gnt_o`=0 and all slave outputs are 0.
  - At an edge where any `m_cyc_i` bit is high: grant the first requester found searching `last+1, last+2, …` modulo NUM_MASTERS.
  - At that edge set `gnt_o`, load `last` with the winner, and go to OWN.
- OWN, with winner g:
  - `s_cyc_o`=`m_cyc_i[g]`, `s_stb_o`=`m_stb_i[g]` & !`err_pulse`.
  - `s_we_o`, `s_adr_o`, `s_dat_o` follow master g combinationally.
  - `m_ack_o[g]`=`s_ack_i`; `m_err_o[g]`=`s_err_i` | `err_pulse`.
  - All other masters see ack=0 and err=0.
  - At an edge with `m_cyc_i[g]`=0: clear `gnt_o` and go to IDLE. The next grant comes at the following edge, giving one dead cycle between owners.
- Ungranted masters are held off: they receive no ack. Their strobe is ignored, not queued.
- Watchdog, active only when TIMEOUT>0:
  - Counter of width clog2(TIMEOUT+1), cleared in IDLE.
  - In OWN it increments at each edge where `s_stb_o` & !`s_ack_i` & !`s_err_i`. It clears at any edge where `s_stb_o` is low, or `s_ack_i` or `s_err_i` is high.
  - When the counter reaches TIMEOUT, `err_pulse` (registered) is high for exactly one cycle and the counter clears.
  - While `err_pulse` is high, `s_stb_o` is forced low.
- Simultaneous events:
  - Slave ack in the same cycle the counter hits TIMEOUT-1: the ack wins and no error is issued.
  - `m_cyc_i[g]` falling while `err_pulse` is pending: the pulse is still driven that cycle, then the FSM returns to IDLE.
- Reset:
  - `wb_rst_n`=0 at any edge forces IDLE, `gnt_o`=0, `last`=NUM_MASTERS-1, counter=0, `err_pulse`=0.
  - This holds mid-transfer too; the aborted master receives no ack.

## Timing
- Values after reset: every output 0, including `m_ack_o`, `m_err_o`, `gnt_o`, `busy_o`, and all `s_*` outputs. `m_dat_o` mirrors `s_dat_i`.
- Grant latency: `m_cyc_i` high before edge E0 gives `gnt_o` high after E0. The slave sees the strobe in cycle E0..E1.
- A slave that acks combinationally (like `coreport`) completes a single access 1 cycle after request.
- Release: `cyc` low before edge E gives `gnt_o` low after E. A competing master is granted at E+1.
- Error: with a continuously stalled strobe, `m_err_o[g]` rises TIMEOUT cycles after `s_stb_o` first goes high, and lasts 1 cycle.
- Ack and data pass through combinationally with no added latency inside a grant.

## Test plan
- Master 0 alone writes 0xA5 to address 0x00 → `gnt_o`=01 after 1 edge; `s_adr_o`=0x00, `s_dat_o`=0xA5; `m_ack_o`=01 while strobed; `gnt_o`=00 one edge after `cyc` drops.
- Masters 0 and 1 request at the same edge after reset → 0 is granted first. After 0 releases: one IDLE cycle, then 1 is granted. 1 reads address 0x04 and gets the slave's DDR value on `m_dat_o`.
- Both masters request continuously for 6 transfers → grant order 0,1,0,1,0,1; `m_ack_o` is never asserted for the non-granted master.
- Slave stalled (`s_ack_i`=0), TIMEOUT=15 → `m_err_o[g]` is a single pulse 15 cycles after `s_stb_o` rises, and `s_stb_o` is low that cycle. With TIMEOUT=0 the stall persists with no error.
- Ack arriving in the cycle the counter equals 14 → ack is delivered, no error, counter cleared.
- `wb_rst_n`=0 for one edge during master 1's burst → `gnt_o`=00 and `busy_o`=0 next cycle. A subsequent 0/1 contention grants master 0.
